// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register offsets, STATUS bit
// positions and the serializer state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_OVF   = 2;
  localparam int STATUS_EMPTY = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: takes one byte per valid/ready handshake and shifts it out
// LSB first, each bit held for DIVISOR clock cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVISOR = 434
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int                CW       = cnt_width(DIVISOR);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DIVISOR - 1);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (baud_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_o = 1'b0;

    if (state_q != TX_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          shift_d = data_i;
          baud_d  = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        // Accepting the next byte here chains frames with no idle gap.
        if (bit_end) begin
          ready_o = 1'b1;
          if (valid_i) begin
            shift_d = data_i;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level is registered from the current state, so it lags the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy_o = (state_q != TX_IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/uart_io.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, a small TX FIFO
// with sticky overflow, feeding the uart_tx serializer.
module uart_io
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] uart_addr_i,
  input  logic        uart_rstrb_i,
  output logic [31:0] uart_rdata_o,
  input  logic [3:0]  uart_wmask_i,
  input  logic [31:0] uart_wdata_i,
  output logic        tx_o
);

  localparam int DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
  localparam int PTR_W   = cnt_width(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [1:0]  reg_sel;
  logic        push_req, push, pop;
  logic        fifo_empty, fifo_full;
  logic        tx_ready, tx_busy;
  logic [31:0] status_w;
  logic        unused_bits;

  assign reg_sel    = uart_addr_i[3:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_req   = uart_wmask_i[0] && (reg_sel == REG_TXDATA);
  assign pop        = !fifo_empty && tx_ready;
  // A full FIFO can still take a byte when the serializer drains one in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    status_w               = '0;
    status_w[STATUS_BUSY]  = !fifo_empty || tx_busy;
    status_w[STATUS_FULL]  = fifo_full;
    status_w[STATUS_OVF]   = ovf_q;
    status_w[STATUS_EMPTY] = fifo_empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (uart_rstrb_i) begin
      rdata_d = (reg_sel == REG_STATUS) ? status_w : '0;
      if (reg_sel == REG_STATUS) begin
        ovf_d = 1'b0;
      end
    end
    // A drop in the same cycle as the clearing read must not be lost.
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= uart_wdata_i[7:0];
    end
  end

  uart_tx #(
    .DIVISOR (DIVISOR)
  ) u_tx (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i  (mem_q[rd_ptr_q]),
    .valid_i (!fifo_empty),
    .ready_o (tx_ready),
    .busy_o  (tx_busy),
    .tx_o    (tx_o)
  );

  assign uart_rdata_o = rdata_q;
  assign unused_bits  = ^{uart_addr_i[31:4], uart_addr_i[1:0],
                          uart_wmask_i[3:1], uart_wdata_i[31:8]};

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io: a cycle-level queue model predicts frames and
// register reads; a separate line/bus monitor decodes tx_o and checks them.
module tb_uart_io;

  localparam int CLK_HZ = 4000000;
  localparam int BAUD   = 1000000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [7:0] data;
    int         fall_cyc;
  } frame_t;

  logic        clk_i        = 1'b0;
  logic        rst_n_i      = 1'b1;
  logic [31:0] uart_addr_i  = '0;
  logic        uart_rstrb_i = 1'b0;
  logic [31:0] uart_rdata_o;
  logic [3:0]  uart_wmask_i = '0;
  logic [31:0] uart_wdata_i = '0;
  logic        tx_o;

  uart_io #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .uart_addr_i  (uart_addr_i),
    .uart_rstrb_i (uart_rstrb_i),
    .uart_rdata_o (uart_rdata_o),
    .uart_wmask_i (uart_wmask_i),
    .uart_wdata_i (uart_wdata_i),
    .tx_o         (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: queued bytes, cycles left in the current frame.
  logic [7:0]  fifo_m [$];
  int          ser_left = 0;
  logic        ovf_m    = 1'b0;
  frame_t      exp_q [$];
  logic [31:0] rd_q [$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wmask,
                               input logic [31:0] wdata, input logic rstrb);
    uart_addr_i  = addr;
    uart_wmask_i = wmask;
    uart_wdata_i = wdata;
    uart_rstrb_i = rstrb;
    @(negedge clk_i);
    uart_wmask_i = '0;
    uart_rstrb_i = 1'b0;
  endtask

  function automatic logic [39:0] frame_pattern(input logic [7:0] d);
    logic [9:0]  bits;
    logic [39:0] p;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) p[i] = bits[i / DIV];
    return p;
  endfunction

  // Behavioural model, evaluated once per rising edge from the pre-edge state.
  always @(posedge clk_i or negedge rst_n_i) begin : model
    logic [31:0] st;
    logic        pop, full_pre, push_req, ovf_set;
    logic [7:0]  b;
    if (!rst_n_i) begin
      fifo_m.delete();
      exp_q.delete();
      rd_q.delete();
      ser_left = 0;
      ovf_m    = 1'b0;
    end else begin
      cyc++;
      st       = '0;
      st[0]    = (fifo_m.size() > 0) || (ser_left > 0);
      st[1]    = (fifo_m.size() == DEPTH);
      st[2]    = ovf_m;
      st[3]    = (fifo_m.size() == 0);
      full_pre = (fifo_m.size() == DEPTH);
      if (uart_rstrb_i) rd_q.push_back((uart_addr_i[3:2] == 2'd1) ? st : 32'd0);
      pop = (fifo_m.size() > 0) && (ser_left <= 1);
      if (pop) begin
        b = fifo_m.pop_front();
        exp_q.push_back('{data: b, fall_cyc: cyc + 1});
        ser_left = 10 * DIV;
      end else if (ser_left > 0) begin
        ser_left--;
      end
      push_req = uart_wmask_i[0] && (uart_addr_i[3:2] == 2'd0);
      ovf_set  = 1'b0;
      if (push_req) begin
        if (!full_pre || pop) fifo_m.push_back(uart_wdata_i[7:0]);
        else ovf_set = 1'b1;
      end
      if (uart_rstrb_i && uart_addr_i[3:2] == 2'd1) ovf_m = 1'b0;
      if (ovf_set) ovf_m = 1'b1;
    end
  end

  int          mon_idx  = -1;
  logic        prev_tx  = 1'b1;
  logic [39:0] mon_bits = '0;
  logic [31:0] hold_val = '0;
  frame_t      cur;
  logic        cur_ok   = 1'b0;

  // Monitor: checks read data and decodes frames on tx_o at falling edges.
  always @(negedge clk_i) begin : monitor
    logic [7:0] dec;
    if (!rst_n_i) begin
      mon_idx  = -1;
      prev_tx  = 1'b1;
      hold_val = '0;
      checkOutput("reset_tx_idle", {31'd0, tx_o}, 32'd1);
      checkOutput("reset_rdata", uart_rdata_o, 32'd0);
    end else begin
      if (rd_q.size() > 0) begin
        hold_val = rd_q.pop_front();
        checkOutput("read_data", uart_rdata_o, hold_val);
      end else begin
        checkOutput("read_hold", uart_rdata_o, hold_val);
      end
      if (mon_idx < 0) begin
        if (prev_tx && !tx_o) begin
          if (exp_q.size() == 0) begin
            cur_ok = 1'b0;
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: start bit at cycle %0d, expected line idle", cyc);
          end else begin
            cur    = exp_q.pop_front();
            cur_ok = 1'b1;
            checkOutput("start_cycle", cyc, cur.fall_cyc);
          end
          mon_bits[0] = tx_o;
          mon_idx     = 1;
        end
      end else begin
        mon_bits[mon_idx] = tx_o;
        mon_idx++;
        if (mon_idx == 10 * DIV) begin
          if (cur_ok) begin
            for (int k = 0; k < 8; k++) dec[k] = mon_bits[(k + 1) * DIV + DIV / 2];
            checkOutput("frame_byte", {24'd0, dec}, {24'd0, cur.data});
            checks++;
            if (mon_bits !== frame_pattern(cur.data)) begin
              errors++;
              $display("[TB] FAIL frame_bits byte 0x%02h: got %010h, expected %010h",
                       cur.data, mon_bits, frame_pattern(cur.data));
            end
          end
          mon_idx = -1;
        end
      end
      prev_tx = tx_o;
    end
  end

  task automatic waitDrain();
    int n = 0;
    while (!(fifo_m.size() == 0 && ser_left == 0 && exp_q.size() == 0 && mon_idx < 0)
           && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("drain_timeout", {31'd0, (n < 2000)}, 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin : stimulus
    logic [31:0] a;
    int unsigned r;

    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("async_reset_tx", {31'd0, tx_o}, 32'd1);
    checkOutput("async_reset_rdata", uart_rdata_o, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] idle register reads");
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    applyStimulus(32'h8, 4'h0, 32'h0, 1'b1);
    repeat (3) @(negedge clk_i);

    $display("[TB] single frame 0x55");
    applyStimulus(32'h0, 4'h1, 32'h0000_0055, 1'b0);
    repeat (5) @(negedge clk_i);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    repeat (20) @(negedge clk_i);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);

    $display("[TB] back-to-back frames");
    applyStimulus(32'h0, 4'h1, 32'h0000_00A1, 1'b0);
    applyStimulus(32'h0, 4'h1, 32'h0000_003C, 1'b0);
    waitDrain();

    $display("[TB] overflow");
    for (int i = 0; i < 6; i++) applyStimulus(32'h0, 4'hF, 32'h10 + i, 1'b0);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] ignored writes");
    applyStimulus(32'h0, 4'b0010, 32'h0000_00EE, 1'b0);
    applyStimulus(32'h4, 4'hF, 32'h0000_00FF, 1'b1);
    applyStimulus(32'hC, 4'hF, 32'h0000_00AB, 1'b1);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    waitDrain();

    $display("[TB] randomized bus traffic");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      case (r)
        0, 1: begin
          a[3:2] = 2'd0;
          applyStimulus(a, 4'h1 | 4'($urandom_range(0, 15)), $urandom, 1'b0);
        end
        2, 3: begin
          a[3:2] = 2'd1;
          applyStimulus(a, 4'h0, 32'h0, 1'b1);
        end
        4: begin
          a[3:2] = 2'd1;
          applyStimulus(a, 4'hF, $urandom, 1'b1);
        end
        5: begin
          a[3:2] = 2'd0;
          applyStimulus(a, 4'hF, $urandom, 1'b1);
        end
        6: begin
          a[3:2] = 2'($urandom_range(2, 3));
          applyStimulus(a, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
        end
        7: begin
          a[3:2] = 2'd0;
          applyStimulus(a, 4'b1110 & 4'($urandom_range(0, 15)), $urandom, 1'b0);
        end
        default: applyStimulus(a, 4'h0, 32'h0, 1'b0);
      endcase
    end
    waitDrain();

    $display("[TB] reset during data bit 3");
    applyStimulus(32'h0, 4'h1, 32'h0000_00F0, 1'b0);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    repeat (17) @(posedge clk_i);
    #1;
    checkOutput("pre_reset_tx_low", {31'd0, tx_o}, 32'd0);
    #1 rst_n_i = 1'b0;
    #1;
    checkOutput("midframe_reset_tx", {31'd0, tx_o}, 32'd1);
    checkOutput("midframe_reset_rdata", uart_rdata_o, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    applyStimulus(32'h4, 4'h0, 32'h0, 1'b1);
    repeat (100) @(negedge clk_i);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
